pc_fetch_ctrl: RTL and testbench

- Multi-cycle instruction-fetch sequencer for the MIPS core.
- Owns the architectural PC register and runs a request/ready handshake to instruction memory.
- Presents fetched instructions to decode with a valid/ack handshake.
- Applies control-flow redirects (branch, jump, jr) using the NPCOp encoding, including redirects that arrive while a fetch is outstanding.

---
 rtl/pc_fetch_ctrl_pkg.sv | 18 +
 rtl/redir_target_calc.sv | 33 +++
 rtl/pc_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings for the instruction-fetch sequencer: NPCOp redirect codes
// and fetch FSM state codes.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JR     = 2'd3
    } npc_op_e;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_HOLD = 2'd1,
        FS_ERR  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/redir_target_calc.sv
// Combinational redirect-target computation from the NPCOp encoding; flags
// targets that are not word aligned.
module redir_target_calc
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [1:0]  redir_op,
    input  logic [31:0] redir_pc,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_rs,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] p4;

    assign p4 = redir_pc + 32'd4;

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        target = p4;
        case (npc_op_e'(redir_op))
            NPC_PLUS4:  target = p4;
            NPC_BRANCH: target = p4 + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
            NPC_JUMP:   target = {p4[31:28], redir_imm, 2'b00};
            NPC_JR:     target = redir_rs;
            default:    target = p4;
        endcase
    end

    assign misaligned = |target[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Multi-cycle fetch sequencer: owns the PC, handshakes with instruction memory,
// holds one instruction for decode and applies branch/jump/jr redirects.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned TO_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ack,
    input  logic        redir_valid,
    input  logic [1:0]  redir_op,
    input  logic [31:0] redir_pc,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_rs,
    output logic        fetch_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    fetch_state_e    state, state_n;
    logic [31:0]     pc, pc_n;
    logic [31:0]     inst_q, inst_n;
    logic [31:0]     inst_pc_q, inst_pc_n;
    logic            pend, pend_n;
    logic [31:0]     pend_tgt, pend_tgt_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;

    logic [31:0]     target;
    logic            misaligned;

    redir_target_calc u_target (
        .redir_op   (redir_op),
        .redir_pc   (redir_pc),
        .redir_imm  (redir_imm),
        .redir_rs   (redir_rs),
        .target     (target),
        .misaligned (misaligned)
    );

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        inst_n     = inst_q;
        inst_pc_n  = inst_pc_q;
        pend_n     = pend;
        pend_tgt_n = pend_tgt;
        to_cnt_n   = to_cnt;

        case (state)
            FS_REQ: begin
                if (redir_valid && misaligned) begin
                    state_n = FS_ERR;
                end else if (imem_ready) begin
                    to_cnt_n = '0;
                    pend_n   = 1'b0;
                    // A redirect seen this cycle or earlier makes the returned word stale.
                    if (redir_valid) begin
                        pc_n = target;
                    end else if (pend) begin
                        pc_n = pend_tgt;
                    end else begin
                        inst_n    = imem_rdata;
                        inst_pc_n = pc;
                        pc_n      = pc + 32'd4;
                        state_n   = FS_HOLD;
                    end
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                    if (redir_valid) begin
                        pend_n     = 1'b1;
                        pend_tgt_n = target;
                    end
                    if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
                        state_n = FS_ERR;
                    end
                end
            end
            FS_HOLD: begin
                if (redir_valid) begin
                    if (misaligned) begin
                        state_n = FS_ERR;
                    end else begin
                        pc_n    = target;
                        state_n = FS_REQ;
                    end
                end else if (inst_ack) begin
                    state_n = FS_REQ;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FS_REQ;
            pc        <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            pend      <= 1'b0;
            pend_tgt  <= '0;
            to_cnt    <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            inst_q    <= inst_n;
            inst_pc_q <= inst_pc_n;
            pend      <= pend_n;
            pend_tgt  <= pend_tgt_n;
            to_cnt    <= to_cnt_n;
        end
    end

    assign imem_req   = (state == FS_REQ);
    assign imem_addr  = pc;
    assign inst_valid = (state == FS_HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = (state == FS_ERR);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized
// traffic, all compared against a transaction-level fetch model.
module tb_pc_fetch_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ack;
    logic        redir_valid;
    logic [1:0]  redir_op;
    logic [31:0] redir_pc;
    logic [25:0] redir_imm;
    logic [31:0] redir_rs;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the fetch unit should be doing, in plain terms.
    logic [31:0] m_pc;
    bit          m_held;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    bit          m_pend;
    logic [31:0] m_ptgt;
    int          m_wait;
    bit          m_err;

    pc_fetch_ctrl #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (TIMEOUT),
        .TO_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ack    (inst_ack),
        .redir_valid (redir_valid),
        .redir_op    (redir_op),
        .redir_pc    (redir_pc),
        .redir_imm   (redir_imm),
        .redir_rs    (redir_rs),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] target_of(input logic [1:0] op, input logic [31:0] rpc,
                                              input logic [25:0] imm, input logic [31:0] rs);
        int          off;
        logic [31:0] nxt;
        nxt = rpc + 32'd4;
        off = int'($signed(imm[15:0]));
        case (op)
            2'd0:    return nxt;
            2'd1:    return nxt + 32'(off * 4);
            2'd2:    return (nxt & 32'hF000_0000) | (32'(imm) * 32'd4);
            default: return rs;
        endcase
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0000_3000;
        m_held = 0;
        m_inst = '0;
        m_ipc  = '0;
        m_pend = 0;
        m_ptgt = '0;
        m_wait = 0;
        m_err  = 0;
    endtask

    task automatic idle();
        rst         = 1'b0;
        imem_ready  = 1'b0;
        imem_rdata  = '0;
        inst_ack    = 1'b0;
        redir_valid = 1'b0;
        redir_op    = 2'd0;
        redir_pc    = '0;
        redir_imm   = '0;
        redir_rs    = '0;
    endtask

    // Compare DUT outputs with the model, clock once, advance the model.
    task automatic tick();
        logic [31:0] tgt;
        bit          bad;
        check("imem_req", 32'(imem_req), 32'(!m_err && !m_held));
        check("imem_addr", imem_addr, m_pc);
        check("inst_valid", 32'(inst_valid), 32'(!m_err && m_held));
        check("fetch_err", 32'(fetch_err), 32'(m_err));
        if (!m_err && m_held) begin
            check("inst", inst, m_inst);
            check("inst_pc", inst_pc, m_ipc);
        end
        tgt = target_of(redir_op, redir_pc, redir_imm, redir_rs);
        bad = (tgt % 4) != 0;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_err) begin
            // dead until reset
        end else if (!m_held) begin
            if (redir_valid && bad) begin
                m_err = 1;
            end else if (imem_ready) begin
                if (redir_valid)  m_pc = tgt;
                else if (m_pend)  m_pc = m_ptgt;
                else begin
                    m_held = 1;
                    m_inst = imem_rdata;
                    m_ipc  = m_pc;
                    m_pc   = m_pc + 32'd4;
                end
                m_pend = 0;
                m_wait = 0;
            end else begin
                m_wait++;
                if (redir_valid) begin
                    m_pend = 1;
                    m_ptgt = tgt;
                end
                if (TIMEOUT != 0 && m_wait == TIMEOUT) m_err = 1;
            end
        end else begin
            if (redir_valid && bad) begin
                m_err = 1;
            end else if (redir_valid) begin
                m_held = 0;
                m_pc   = tgt;
            end else if (inst_ack) begin
                m_held = 0;
            end
        end
        if (m_err) m_held = 0;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        int ready_pct;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        idle();

        // Reset state
        check("rst_addr", imem_addr, 32'h0000_3000);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);

        // Back-to-back fetch with ready and ack tied high
        imem_ready = 1'b1; inst_ack = 1'b1; imem_rdata = 32'hA000_0000;
        tick();
        check("seq_valid0", 32'(inst_valid), 32'd1);
        check("seq_ipc0", inst_pc, 32'h0000_3000);
        check("seq_inst0", inst, 32'hA000_0000);
        imem_rdata = 32'hA000_0001;
        tick();
        check("seq_addr1", imem_addr, 32'h0000_3004);
        check("seq_req1", 32'(imem_req), 32'd1);
        tick();
        check("seq_ipc1", inst_pc, 32'h0000_3004);

        // Branch back by two words, arriving together with the ack
        idle();
        inst_ack = 1'b1; redir_valid = 1'b1; redir_op = 2'd1;
        redir_pc = 32'h0000_3004; redir_imm = 26'h000_FFFE;
        tick();
        idle();
        check("br_valid", 32'(inst_valid), 32'd0);
        check("br_addr", imem_addr, 32'h0000_3000);

        // Jump while memory stalls; stale data dropped
        tick();
        redir_valid = 1'b1; redir_op = 2'd2; redir_pc = 32'h0000_3010; redir_imm = 26'h000_0C10;
        tick();
        idle();
        repeat (3) tick();
        check("stall_addr", imem_addr, 32'h0000_3000);
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        idle();
        check("jmp_valid", 32'(inst_valid), 32'd0);
        check("jmp_addr", imem_addr, 32'h0000_3040);

        // Two redirects while waiting: newest wins
        redir_valid = 1'b1; redir_op = 2'd2; redir_pc = 32'h0000_3040; redir_imm = 26'h000_0100;
        tick();
        redir_op = 2'd3; redir_rs = 32'h0000_4000;
        tick();
        idle();
        imem_ready = 1'b1;
        tick();
        idle();
        check("two_redir_addr", imem_addr, 32'h0000_4000);

        // Misaligned jr target
        redir_valid = 1'b1; redir_op = 2'd3; redir_rs = 32'h0000_3002;
        tick();
        idle();
        check("mis_err", 32'(fetch_err), 32'd1);
        check("mis_addr", imem_addr, 32'h0000_4000);
        imem_ready = 1'b1; inst_ack = 1'b1; redir_valid = 1'b1; redir_rs = 32'h0000_5000;
        repeat (3) tick();
        check("err_req", 32'(imem_req), 32'd0);
        do_reset();
        check("err_rst_addr", imem_addr, 32'h0000_3000);
        check("err_rst_flag", 32'(fetch_err), 32'd0);

        // Timeout after exactly TIMEOUT request cycles
        repeat (TIMEOUT - 1) tick();
        check("to_early", 32'(fetch_err), 32'd0);
        tick();
        check("to_hit", 32'(fetch_err), 32'd1);
        do_reset();

        // PC wrap-around at the top of the address space
        redir_valid = 1'b1; redir_op = 2'd3; redir_rs = 32'hFFFF_FFFC;
        tick();
        idle();
        imem_ready = 1'b1;
        tick();
        check("wrap_pc", imem_addr, 32'hFFFF_FFFC);
        imem_rdata = 32'h1234_5678;
        tick();
        idle();
        check("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_next", imem_addr, 32'h0000_0000);
        do_reset();

        // Randomized traffic in segments of varying memory responsiveness
        for (int seg = 0; seg < 80; seg++) begin
            case ($urandom_range(0, 3))
                0:       ready_pct = 0;
                1:       ready_pct = 30;
                2:       ready_pct = 70;
                default: ready_pct = 100;
            endcase
            for (int c = 0; c < int'($urandom_range(10, 40)); c++) begin
                rst         = (m_err ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0));
                imem_ready  = ($urandom_range(0, 99) < ready_pct);
                imem_rdata  = $urandom;
                inst_ack    = $urandom_range(0, 1) == 1;
                redir_valid = $urandom_range(0, 7) == 0;
                redir_op    = 2'($urandom_range(0, 3));
                redir_pc    = $urandom & 32'hFFFF_FFFC;
                redir_imm   = 26'($urandom);
                redir_rs    = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 15) == 0) redir_rs[1:0] = 2'($urandom_range(1, 3));
                tick();
            end
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
